// File: rtl/cla_nibble_serial_adder.sv
// Serial adder that processes one 4-bit carry-lookahead nibble per clock.
// Defining CLA_OVF_EN adds the signed-overflow output port ovf.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] KLAST = CW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CW-1:0]    k;
  logic             accept;
  logic [3:0]       p, g, nsum;
  logic             c1, c2, c3, c4;
  logic [WIDTH+3:0] sum_ext;

  // Lookahead carries are flat sums of products of p/g/carry, with no ripple.
  always_comb begin
    p  = opa[3:0] ^ opb[3:0];
    g  = opa[3:0] & opb[3:0];
    c1 = g[0] | (p[0] & carry);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & carry);
    nsum    = p ^ {c3, c2, c1, carry};
    sum_ext = {nsum, sum};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (k == KLAST) state_nx = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Each nibble sum enters at the MSB end; after NIB shifts nibble 0 lands at [3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CLA_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      k     <= '0;
    end else if (busy) begin
      opa   <= opa >> 4;
      opb   <= opb >> 4;
      carry <= c4;
      k     <= k + CW'(1);
      sum   <= sum_ext[WIDTH+3:4];
      if (k == KLAST) begin
        cout <= c4;
`ifdef CLA_OVF_EN
        ovf  <= c3 ^ c4;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder at WIDTH=16 and WIDTH=8.
// Expected results come from plain integer addition of the operands.
module tb_cla_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st16 = 1'b0, st8 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ci16 = 1'b0, ci8 = 1'b0;
  logic        rdy16, bsy16, dn16, co16, rdy8, bsy8, dn8, co8;
  logic [15:0] s16;
  logic [7:0]  s8;
`ifdef CLA_OVF_EN
  logic        ov16, ov8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .a(a16), .b(b16), .cin(ci16),
    .ready(rdy16), .busy(bsy16), .done(dn16), .sum(s16), .cout(co16)
`ifdef CLA_OVF_EN
    , .ovf(ov16)
`endif
  );

  cla_nibble_serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
    .ready(rdy8), .busy(bsy8), .done(dn8), .sum(s8), .cout(co8)
`ifdef CLA_OVF_EN
    , .ovf(ov8)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  // poke: drive a stray start with junk operands during the first BUSY cycle.
  task automatic run_add(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input bit poke);
    int unsigned wb, mask, aa, bb, r, es, ec;
    int n;
    wb   = w8 ? 8 : 16;
    mask = (1 << wb) - 1;
    aa   = 32'(a) & mask;
    bb   = 32'(b) & mask;
    r    = aa + bb + 32'(c);
    es   = r & mask;
    ec   = r >> wb;
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; ci8 = c; st8 = 1'b1; end
    else    begin a16 = a; b16 = b; ci16 = c; st16 = 1'b1; end
    @(negedge clk);
    n = 1;
    st8 = 1'b0; st16 = 1'b0;
    chk("busy_after_accept", 32'(w8 ? bsy8 : bsy16), 1);
    chk("no_done_after_accept", 32'(w8 ? dn8 : dn16), 0);
    if (poke) begin
      if (w8) begin st8 = 1'b1; a8 = 8'hAA; b8 = 8'hFF; ci8 = 1'b1; end
      else    begin st16 = 1'b1; a16 = 16'hAAAA; b16 = 16'hFFFF; ci16 = 1'b1; end
    end
    while (!(w8 ? dn8 : dn16) && n < 40) begin
      @(negedge clk);
      n++;
      st8 = 1'b0; st16 = 1'b0;
    end
    chk("done_latency", 32'(n), 32'(wb / 4 + 1));
    chk("sum", w8 ? 32'(s8) : 32'(s16), es);
    chk("cout", 32'(w8 ? co8 : co16), ec);
`ifdef CLA_OVF_EN
    chk("ovf", 32'(w8 ? ov8 : ov16),
        32'(((aa >> (wb - 1)) & 1) == ((bb >> (wb - 1)) & 1) &&
            ((es >> (wb - 1)) & 1) != ((aa >> (wb - 1)) & 1)));
`endif
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{a: 16'h1234, b: 16'h4321, cin: 1'b0, s: 16'h5555, co: 1'b0};
    tbl[1] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, co: 1'b1};
    tbl[2] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, co: 1'b1};
    tbl[3] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0};
    tbl[4] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, s: 16'hFFFF, co: 1'b1};
    tbl[5] = '{a: 16'h0F0F, b: 16'h00F1, cin: 1'b0, s: 16'h1000, co: 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(rdy16), 1);
    chk("rst_busy", 32'(bsy16), 0);
    chk("rst_done", 32'(dn16), 0);
    chk("rst_sum", 32'(s16), 0);
    chk("rst_cout", 32'(co16), 0);
    chk("rst_ready8", 32'(rdy8), 1);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_add(1'b0, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
      chk("tbl_sum", 32'(s16), 32'(tbl[i].s));
      chk("tbl_cout", 32'(co16), 32'(tbl[i].co));
`ifdef CLA_OVF_EN
      if (i == 3) chk("tbl_ovf_7fff", 32'(ov16), 1);
      if (i == 1) chk("tbl_ovf_ffff", 32'(ov16), 0);
`endif
      @(negedge clk);
      chk("done_one_cycle", 32'(dn16), 0);
      chk("idle_ready", 32'(rdy16), 1);
      chk("sum_held", 32'(s16), 32'(tbl[i].s));
    end

    // Stray start during BUSY is ignored, then a back-to-back start from DONE.
    run_add(1'b0, 16'h00F0, 16'h0010, 1'b0, 1'b1);
    chk("ignored_start_sum", 32'(s16), 32'h0100);
    run_add(1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0);
    chk("b2b_sum", 32'(s16), 32'h0003);
    @(negedge clk);

    // Reset two edges into an add discards it.
    a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b1; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(rdy16), 1);
    chk("midrst_busy", 32'(bsy16), 0);
    chk("midrst_sum", 32'(s16), 0);
    chk("midrst_cout", 32'(co16), 0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (dn16) seen++;
        @(negedge clk);
      end
      chk("midrst_no_done", 32'(seen), 0);
    end
    run_add(1'b0, 16'h1111, 16'h2222, 1'b1, 1'b0);
    @(negedge clk);

    // Reset and start together: reset wins.
    rst = 1'b1; st16 = 1'b1; a16 = 16'h0005; b16 = 16'h0005;
    @(negedge clk);
    rst = 1'b0; st16 = 1'b0;
    chk("rst_start_busy", 32'(bsy16), 0);
    chk("rst_start_ready", 32'(rdy16), 1);
    @(negedge clk);
    chk("rst_start_still_idle", 32'(bsy16), 0);

    run_add(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("w8_wrap_sum", 32'(s8), 0);
    chk("w8_wrap_cout", 32'(co8), 1);
    run_add(1'b1, 16'h0012, 16'h0034, 1'b1, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_add(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_add(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
- Multi-cycle adder built from the 4-bit carry-lookahead slice.
- Consumes per-nibble propagate (a^b) and generate (a&b) terms and computes the lookahead carries and sum bits for one nibble per cycle.
- Chains carry-out between nibbles through a register, so a WIDTH-bit add completes in WIDTH/4 cycles.
- Sits directly downstream of the propagate/generate stage and replaces a wide combinational carry chain with an area-cheap serial datapath.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, nibble count; localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an add; sampled only when ready=1.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- cin  input  1  carry-in to nibble 0; captured on an accepted start.
- ready  output  1  high in IDLE and DONE; block can accept start.
- busy  output  1  high in BUSY.
- done  output  1  one-cycle pulse when sum/cout become valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- cout  output  1  carry out of the MSB nibble; held like sum.

Behaviour:
- One clock. Reset is synchronous and active-high: all state updates on the rising edge of clk, and rst sampled high forces the reset state on that edge.
- FSM states: IDLE, BUSY, DONE.
- Reset (rst=1 at an edge) applies from any state, including mid-BUSY:
  - state goes to IDLE; sum=0, cout=0, done=0, busy=0, ready=1.
  - nibble counter=0; carry register=0; operand registers=0.
  - any in-flight add is discarded and produces no done.
- Accept: start=1 in IDLE or DONE at edge T.
  - Latch a, b, cin into the operand and carry registers; clear counter; state goes to BUSY.
  - sum/cout keep their previous values until overwritten.
- BUSY, each edge while counter k < NIB:
  - Take low nibble of the operand registers: p=a[3:0]^b[3:0], g=a[3:0]&b[3:0], c0=carry register.
  - Lookahead carries, all computed from p/g/c0 only, no ripple:
    - c1=g0|p0c0
    - c2=g1|p1g0|p1p0c0
    - c3=g2|p2g1|p2p1g0|p2p1p0c0
    - c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0
  - Nibble sum = p ^ {c3,c2,c1,c0}; shifted into sum from the MSB end, so after NIB shifts nibble 0 is at bits [3:0].
  - Operand registers shift right by 4; carry register <= c4; k increments.
- When k reaches NIB-1, that edge writes the final nibble: cout <= c4 and state goes to DONE.
- DONE lasts exactly one cycle with done=1.
- Latency: start accepted at edge T gives done=1 in the cycle following edge T+NIB (T+4 for WIDTH=16).
- After DONE:
  - next edge goes to IDLE if start=0.
  - if start=1 in DONE, accept it (back-to-back); done does not repeat.
- start while busy=1 is ignored and has no side effects; a/b/cin may change freely during BUSY.
- Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1).
- Simultaneous rst=1 and start=1: reset wins; nothing is accepted.

Optional Feature:
- Macro: CLA_OVF_EN.
- Defined: adds output port ovf (1 bit) = carry into the MSB (c3 of the last nibble) XOR c4 of the last nibble, i.e. two's-complement signed overflow. Updated on the same edge as cout and held the same way; reset value 0.
- Undefined: port ovf is absent and no extra logic is built; all other behaviour is identical.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, start at edge T -> busy for 4 cycles, done pulse after edge T+4, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Exercises carry crossing all nibble boundaries.
- Accept a=0x00F0, b=0x0010; assert start with a=0xAAAA during BUSY -> second start ignored, result sum=0x0100. Then assert start in the DONE cycle with a=0x0001, b=0x0002 -> accepted, next done gives sum=0x0003.
- Mid-operation reset: start, then rst=1 at edge T+2 -> IDLE next cycle, sum=0, cout=0, no done pulse. A fresh add afterwards completes correctly.
- With CLA_OVF_EN: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0xFFFF, b=0x0001 -> cout=1, ovf=0.
- Random regression: 1000 random a/b/cin for WIDTH=16 and WIDTH=8 -> {cout,sum} == a+b+cin and done latency == NIB+1 cycles from start every time.
